// File: rtl/hdr_deframer_pkg.sv
// Purpose : shared state encoding and header constants for the header deframer.
// Latency : n/a (package).
// Backpr. : n/a (package).
//
// Contents: state_t (HUNT, H0..H3, PAY), HDR_WORDS, SYNC_WORD, is_sync().
package hdr_deframer_pkg;

    // HUNT searches for a sync word; H0..H3 are header word positions; PAY is payload.
    typedef enum logic [2:0] {
        HUNT = 3'd0,
        H0   = 3'd1,
        H1   = 3'd2,
        H2   = 3'd3,
        H3   = 3'd4,
        PAY  = 3'd5
    } state_t;

    localparam int unsigned HDR_WORDS = 4;
    localparam logic [31:0] SYNC_WORD = 32'h0;

    function automatic logic is_sync(input logic [31:0] w);
        return w == SYNC_WORD;
    endfunction

endpackage

// File: rtl/hdr_deframer_if.sv
// Purpose : bundles the deframer's input stream and its decoded outputs.
// Latency : n/a (interface).
// Backpr. : none; the stream is accepted whenever din_valid is high.
//
// Ports   : din/din_valid (source -> deframer); frame_count, pps_count, hdr_valid,
//           payload/payload_valid/payload_last, locked, sync_err, frame_gap, err_count.
interface hdr_deframer_if
    import hdr_deframer_pkg::*;
#(
    parameter int unsigned ERR_W = 16
);
    logic [31:0]      din;
    logic             din_valid;
    logic [31:0]      frame_count;
    logic [31:0]      pps_count;
    logic             hdr_valid;
    logic [31:0]      payload;
    logic             payload_valid;
    logic             payload_last;
    logic             locked;
    logic             sync_err;
    logic             frame_gap;
    logic [ERR_W-1:0] err_count;

    modport master (
        output din, din_valid,
        input  frame_count, pps_count, hdr_valid, payload, payload_valid,
               payload_last, locked, sync_err, frame_gap, err_count
    );

    modport slave (
        input  din, din_valid,
        output frame_count, pps_count, hdr_valid, payload, payload_valid,
               payload_last, locked, sync_err, frame_gap, err_count
    );
endinterface

// File: rtl/hdr_gap_check.sv
// Purpose : remembers the last good frame_count and flags non-consecutive headers.
// Latency : frame_gap_o one cycle after chk_i; frame_gap_d_o is same-cycle.
// Backpr. : none.
//
// Ports   : clk, rst; chk_i (good header accepted), fc_i (its frame_count);
//           frame_gap_d_o (next-state of the pulse), frame_gap_o (registered pulse).
module hdr_gap_check
    import hdr_deframer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        chk_i,
    input  logic [31:0] fc_i,
    output logic        frame_gap_d_o,
    output logic        frame_gap_o
);
    logic [31:0] prev_q;
    logic        have_prev_q;
    logic        frame_gap_q;

    // The +1 wraps naturally at 32 bits, so 0xFFFFFFFF -> 0 counts as consecutive.
    assign frame_gap_d_o = chk_i && have_prev_q && (fc_i != prev_q + 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            frame_gap_q <= 1'b0;
        end else begin
            frame_gap_q <= frame_gap_d_o;
            if (chk_i) begin
                prev_q      <= fc_i;
                have_prev_q <= 1'b1;
            end
        end
    end

    assign frame_gap_o = frame_gap_q;
endmodule

// File: rtl/hdr_deframer.sv
// Purpose : recovers frame alignment from a header+payload word stream.
// Latency : every output is registered, one cycle after the accepting edge.
// Backpr. : none; a word is consumed on every edge with din_valid high.
//
// Ports   : clk, rst (sync, active high); bus (slave side of hdr_deframer_if).
module hdr_deframer
    import hdr_deframer_pkg::*;
#(
    parameter int unsigned PAYLOAD_WORDS = 256,
    parameter int unsigned ERR_W         = 16
) (
    input  logic          clk,
    input  logic          rst,
    hdr_deframer_if.slave bus
);
    localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_WORDS - 1);

    state_t           state_q;
    logic [15:0]      cnt_q;
    logic [31:0]      fc_sh_q;
    logic [31:0]      pps_sh_q;
    logic [31:0]      fc_q;
    logic [31:0]      pps_q;
    logic [31:0]      pay_q;
    logic             hdr_vld_q;
    logic             pay_vld_q;
    logic             pay_last_q;
    logic             locked_q;
    logic             sync_err_q;
    logic [ERR_W-1:0] err_q;

    logic             good_hdr;
    logic             sync_fail;
    logic             frame_gap_d;
    logic             frame_gap_q;
    logic [1:0]       err_inc;
    logic [ERR_W:0]   err_sum;

    // Header word 3 and the word expected after a payload must both be the sync word.
    assign good_hdr  = bus.din_valid && (state_q == H3) && is_sync(bus.din);
    assign sync_fail = bus.din_valid && ((state_q == H3) || (state_q == H0)) && !is_sync(bus.din);

    // One extra bit catches overflow so the counter saturates instead of wrapping.
    assign err_inc = {1'b0, sync_fail} + {1'b0, frame_gap_d};
    assign err_sum = {1'b0, err_q} + {{(ERR_W-1){1'b0}}, err_inc};

    hdr_gap_check u_gap (
        .clk           (clk),
        .rst           (rst),
        .chk_i         (good_hdr),
        .fc_i          (fc_sh_q),
        .frame_gap_d_o (frame_gap_d),
        .frame_gap_o   (frame_gap_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            fc_sh_q    <= '0;
            pps_sh_q   <= '0;
            fc_q       <= '0;
            pps_q      <= '0;
            pay_q      <= '0;
            hdr_vld_q  <= 1'b0;
            pay_vld_q  <= 1'b0;
            pay_last_q <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
            err_q      <= '0;
        end else begin
            hdr_vld_q  <= 1'b0;
            pay_vld_q  <= 1'b0;
            pay_last_q <= 1'b0;
            sync_err_q <= 1'b0;
            err_q      <= err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];

            if (bus.din_valid) begin
                case (state_q)
                    HUNT: if (is_sync(bus.din)) state_q <= H1;
                    H0: begin
                        if (is_sync(bus.din)) begin
                            state_q <= H1;
                        end else begin
                            sync_err_q <= 1'b1;
                            locked_q   <= 1'b0;
                            state_q    <= HUNT;
                        end
                    end
                    H1: begin
                        fc_sh_q <= bus.din;
                        state_q <= H2;
                    end
                    H2: begin
                        pps_sh_q <= bus.din;
                        state_q  <= H3;
                    end
                    H3: begin
                        if (good_hdr) begin
                            fc_q      <= fc_sh_q;
                            pps_q     <= pps_sh_q;
                            hdr_vld_q <= 1'b1;
                            locked_q  <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= PAY;
                        end else begin
                            sync_err_q <= 1'b1;
                            locked_q   <= 1'b0;
                            state_q    <= HUNT;
                        end
                    end
                    PAY: begin
                        // Frame length comes from the counter alone; zero payload words are data.
                        pay_q     <= bus.din;
                        pay_vld_q <= 1'b1;
                        cnt_q     <= cnt_q + 16'd1;
                        if (cnt_q == LAST_IDX) begin
                            pay_last_q <= 1'b1;
                            state_q    <= H0;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign bus.frame_count   = fc_q;
    assign bus.pps_count     = pps_q;
    assign bus.hdr_valid     = hdr_vld_q;
    assign bus.payload       = pay_q;
    assign bus.payload_valid = pay_vld_q;
    assign bus.payload_last  = pay_last_q;
    assign bus.locked        = locked_q;
    assign bus.sync_err      = sync_err_q;
    assign bus.frame_gap     = frame_gap_q;
    assign bus.err_count     = err_q;
endmodule
